// File: rtl/lcz80_pkg.sv
// Shared encodings for the Z80 block-transfer sequencer: FSM states and
// register-pair indices as seen on the register file address ports.
package lcz80_pkg;

    localparam int WORD_W = 16;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_WR   = 3'd2;
    localparam logic [2:0] ST_UHL  = 3'd3;
    localparam logic [2:0] ST_UDE  = 3'd4;
    localparam logic [2:0] ST_UBC  = 3'd5;
    localparam logic [2:0] ST_DONE = 3'd6;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        RD   = ST_RD,
        WR   = ST_WR,
        UHL  = ST_UHL,
        UDE  = ST_UDE,
        UBC  = ST_UBC,
        DONE = ST_DONE
    } state_t;

    localparam logic [2:0] BC_IDX  = 3'd0;
    localparam logic [2:0] DE_IDX  = 3'd1;
    localparam logic [2:0] HL_IDX  = 3'd2;
    localparam logic [2:0] ALT_OFS = 3'd4;

    function automatic logic [2:0] pair_idx(input logic [2:0] idx, input bit alt);
        return alt ? (idx | ALT_OFS) : idx;
    endfunction

endpackage

// File: rtl/lcz80_incdec16.sv
// Combinational 16-bit +/-1 (modulo 2^16) with a zero flag on the result.
// Zero latency, no handshake.
module lcz80_incdec16
    import lcz80_pkg::*;
(
    input  logic              dir_i,
    input  logic [WORD_W-1:0] val_i,
    output logic [WORD_W-1:0] res_o,
    output logic              zero_o
);

    assign res_o  = dir_i ? (val_i - WORD_W'(1)) : (val_i + WORD_W'(1));
    assign zero_o = (res_o == '0);

endmodule

// File: rtl/lcz80_blkseq.sv
// LDI/LDD/LDIR/LDDR sequencer: per byte RD -> WR (each held until mem_ack), then HL, DE, BC writeback.
// Every state advance is gated by CEN; a pending interrupt ends repeat forms between iterations.
module lcz80_blkseq
    import lcz80_pkg::*;
#(
    parameter bit ALT_SET = 1'b0,
    parameter bit CHK_INT = 1'b1
) (
    input  logic        clk,
    input  logic        RESET_n,
    input  logic        CEN,
    input  logic        start,
    input  logic        dir,
    input  logic        rpt,
    input  logic        int_req,
    output logic        busy,
    output logic        done,
    output logic        rpt_break,
    output logic        pv,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic [2:0]  rf_addr_a,
    output logic [2:0]  rf_addr_b,
    output logic [2:0]  rf_addr_c,
    input  logic [7:0]  rf_doah,
    input  logic [7:0]  rf_doal,
    input  logic [7:0]  rf_dobh,
    input  logic [7:0]  rf_dobl,
    input  logic [7:0]  rf_doch,
    input  logic [7:0]  rf_docl,
    output logic [7:0]  rf_dih,
    output logic [7:0]  rf_dil,
    output logic        rf_weh,
    output logic        rf_wel
);

    localparam logic [2:0] BC_A = pair_idx(BC_IDX, ALT_SET);
    localparam logic [2:0] DE_A = pair_idx(DE_IDX, ALT_SET);
    localparam logic [2:0] HL_A = pair_idx(HL_IDX, ALT_SET);

    state_t      state_q, state_d;
    logic        dir_q, dir_d;
    logic        rpt_q, rpt_d;
    logic        pv_q, pv_d;
    logic        brk_q, brk_d;
    logic [7:0]  data_q, data_d;

    logic [15:0] hl_w, de_w, bc_w;
    logic [15:0] id_val, id_res;
    logic        id_dir, id_zero;

    // HL and DE stay on ports B/C; port A is retargeted only while writing back.
    assign rf_addr_b = HL_A;
    assign rf_addr_c = DE_A;
    assign hl_w      = {rf_dobh, rf_dobl};
    assign de_w      = {rf_doch, rf_docl};
    assign bc_w      = {rf_doah, rf_doal};
    assign pv        = pv_q;

    lcz80_incdec16 u_incdec (
        .dir_i  (id_dir),
        .val_i  (id_val),
        .res_o  (id_res),
        .zero_o (id_zero)
    );

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        rpt_d     = rpt_q;
        pv_d      = pv_q;
        brk_d     = brk_q;
        data_d    = data_q;
        busy      = (state_q != IDLE);
        done      = 1'b0;
        rpt_break = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 16'h0000;
        mem_wdata = 8'h00;
        rf_addr_a = BC_A;
        rf_dih    = 8'h00;
        rf_dil    = 8'h00;
        rf_weh    = 1'b0;
        rf_wel    = 1'b0;
        id_val    = bc_w;
        id_dir    = 1'b1;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dir_d   = dir;
                    rpt_d   = rpt;
                    brk_d   = 1'b0;
                    state_d = RD;
                end
            end
            RD: begin
                mem_req  = 1'b1;
                mem_addr = hl_w;
                if (mem_ack) begin
                    data_d  = mem_rdata;
                    state_d = WR;
                end
            end
            WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = de_w;
                mem_wdata = data_q;
                if (mem_ack) state_d = UHL;
            end
            UHL: begin
                rf_addr_a        = HL_A;
                id_val           = hl_w;
                id_dir           = dir_q;
                {rf_dih, rf_dil} = id_res;
                rf_weh           = 1'b1;
                rf_wel           = 1'b1;
                state_d          = UDE;
            end
            UDE: begin
                rf_addr_a        = DE_A;
                id_val           = de_w;
                id_dir           = dir_q;
                {rf_dih, rf_dil} = id_res;
                rf_weh           = 1'b1;
                rf_wel           = 1'b1;
                state_d          = UBC;
            end
            UBC: begin
                {rf_dih, rf_dil} = id_res;
                rf_weh           = 1'b1;
                rf_wel           = 1'b1;
                pv_d             = !id_zero;
                if (rpt_q && !id_zero && !(CHK_INT && int_req)) begin
                    state_d = RD;
                end else begin
                    // Only an interrupt can stop a repeat form while BC is still non-zero.
                    brk_d   = rpt_q && !id_zero;
                    state_d = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                rpt_break = brk_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            rpt_q   <= 1'b0;
            pv_q    <= 1'b0;
            brk_q   <= 1'b0;
            data_q  <= 8'h00;
        end else if (CEN) begin
            state_q <= state_d;
            dir_q   <= dir_d;
            rpt_q   <= rpt_d;
            pv_q    <= pv_d;
            brk_q   <= brk_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_lcz80_blkseq.sv
// Randomised bench for lcz80_blkseq: a memory/register-file environment, an
// event-level reference model feeding a scoreboard queue, and a separate monitor.
module tb_lcz80_blkseq;

    localparam logic [1:0] K_RD = 2'd0;
    localparam logic [1:0] K_WR = 2'd1;
    localparam logic [1:0] K_RF = 2'd2;
    localparam logic [1:0] K_DN = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] addr;
        logic [15:0] dat;
    } ev_t;

    logic        clk = 1'b0;
    logic        RESET_n = 1'b0;
    logic        CEN = 1'b1;
    logic        start = 1'b0;
    logic        dir = 1'b0;
    logic        rpt = 1'b0;
    logic        int_req = 1'b0;
    logic        busy, done, rpt_break, pv;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic [2:0]  rf_addr_a, rf_addr_b, rf_addr_c;
    logic [7:0]  rf_doah, rf_doal, rf_dobh, rf_dobl, rf_doch, rf_docl;
    logic [7:0]  rf_dih, rf_dil;
    logic        rf_weh, rf_wel;

    logic [7:0]  mem  [0:65535];
    logic [7:0]  mmem [0:65535];
    logic [15:0] regs [0:7];
    int          wait_cfg = 0;
    int          wcnt = 0;
    int          cen_mode = 0;
    int          int_at = 0;
    int          rdn = 0;
    int          checks = 0;
    int          failures = 0;
    bit          sb_en = 1'b1;
    ev_t         exq[$];

    always #5 clk = ~clk;

    assign mem_ack   = mem_req && (wcnt >= wait_cfg);
    assign mem_rdata = mem[mem_addr];
    assign rf_doah   = regs[rf_addr_a][15:8];
    assign rf_doal   = regs[rf_addr_a][7:0];
    assign rf_dobh   = regs[rf_addr_b][15:8];
    assign rf_dobl   = regs[rf_addr_b][7:0];
    assign rf_doch   = regs[rf_addr_c][15:8];
    assign rf_docl   = regs[rf_addr_c][7:0];

    lcz80_blkseq dut (
        .clk(clk), .RESET_n(RESET_n), .CEN(CEN), .start(start), .dir(dir), .rpt(rpt),
        .int_req(int_req), .busy(busy), .done(done), .rpt_break(rpt_break), .pv(pv),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b), .rf_addr_c(rf_addr_c),
        .rf_doah(rf_doah), .rf_doal(rf_doal), .rf_dobh(rf_dobh), .rf_dobl(rf_dobl),
        .rf_doch(rf_doch), .rf_docl(rf_docl), .rf_dih(rf_dih), .rf_dil(rf_dil),
        .rf_weh(rf_weh), .rf_wel(rf_wel)
    );

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] k, input logic [15:0] a, input logic [15:0] d);
        ev_t x;
        x.kind = k;
        x.addr = a;
        x.dat  = d;
        exq.push_back(x);
    endtask

    task automatic resync_mem();
        for (int i = 0; i < 65536; i++) mmem[i] = mem[i];
    endtask

    // Memory and register-file environment: sample at negedge, commit just after posedge.
    initial begin : env
        logic xf, pend, we_s, wh, wl;
        logic [15:0] a_s, rdat;
        logic [7:0]  d_s;
        logic [2:0]  ra;
        forever begin
            @(negedge clk);
            xf   = RESET_n && mem_req && mem_ack && CEN;
            pend = mem_req && !xf;
            we_s = mem_we;
            a_s  = mem_addr;
            d_s  = mem_wdata;
            wh   = RESET_n && CEN && rf_weh;
            wl   = RESET_n && CEN && rf_wel;
            ra   = rf_addr_a;
            rdat = {rf_dih, rf_dil};
            @(posedge clk);
            #1;
            if (!RESET_n) begin
                wcnt = 0;
            end else begin
                if (xf) begin
                    wcnt = 0;
                    if (we_s) mem[a_s] = d_s;
                    else begin
                        rdn++;
                        if (int_at != 0 && rdn == int_at) int_req = 1'b1;
                    end
                end else if (pend) begin
                    wcnt++;
                end
                if (wh) regs[ra][15:8] = rdat[15:8];
                if (wl) regs[ra][7:0]  = rdat[7:0];
            end
            case (cen_mode)
                0:       CEN = 1'b1;
                1:       CEN = ~CEN;
                default: CEN = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: one observable event per enabled cycle, compared in order against the model.
    initial begin : mon
        logic        pp, pwe, have;
        logic [15:0] pa;
        ev_t         ev, ex;
        pp = 1'b0;
        forever begin
            @(negedge clk);
            if (!RESET_n) begin
                pp = 1'b0;
            end else begin
                if (pp) chk("mem_hold", 34'({mem_req, mem_we, mem_addr}), 34'({1'b1, pwe, pa}));
                pp   = mem_req && !(mem_ack && CEN);
                pwe  = mem_we;
                pa   = mem_addr;
                have = 1'b1;
                ev   = '0;
                if (CEN && mem_req && mem_ack) begin
                    ev.kind = mem_we ? K_WR : K_RD;
                    ev.addr = mem_addr;
                    ev.dat  = mem_we ? {8'h00, mem_wdata} : 16'h0000;
                end else if (CEN && (rf_weh || rf_wel)) begin
                    ev.kind = K_RF;
                    ev.addr = {11'b0, rf_weh, rf_wel, rf_addr_a};
                    ev.dat  = {rf_dih, rf_dil};
                end else if (CEN && done) begin
                    ev.kind = K_DN;
                    ev.dat  = {14'b0, pv, rpt_break};
                end else begin
                    have = 1'b0;
                end
                if (have && sb_en) begin
                    if (exq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_event: got %h expected none at %0t", ev, $time);
                    end else begin
                        ex = exq.pop_front();
                        chk("event", ev, ex);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        RESET_n = 1'b0;
        start   = 1'b0;
        int_req = 1'b0;
        repeat (3) step();
        exq.delete();
        resync_mem();
        RESET_n = 1'b1;
        step();
    endtask

    // Reference: each iteration is read (HL), write (DE), then HL, DE, BC written back.
    task automatic issue(input string nm, input logic [15:0] hl, input logic [15:0] de,
                         input logic [15:0] bc, input logic d, input logic r,
                         input int ia, input int wt, input int cm);
        logic [15:0] h, e, b;
        logic [7:0]  v;
        logic        brk;
        int          n, lim, cyc;
        h = hl; e = de; b = bc; n = 0; brk = 1'b0;
        while (1) begin
            push(K_RD, h, 16'h0000);
            v = mmem[h];
            push(K_WR, e, {8'h00, v});
            mmem[e] = v;
            h = d ? h - 16'd1 : h + 16'd1;
            e = d ? e - 16'd1 : e + 16'd1;
            b = b - 16'd1;
            push(K_RF, {11'b0, 2'b11, 3'd2}, h);
            push(K_RF, {11'b0, 2'b11, 3'd1}, e);
            push(K_RF, {11'b0, 2'b11, 3'd0}, b);
            n++;
            if (!r || b == 16'h0000) break;
            if (ia != 0 && n >= ia) begin
                brk = 1'b1;
                break;
            end
        end
        push(K_DN, 16'h0000, {14'b0, (b != 16'h0000), brk});

        regs[2]  = hl;
        regs[1]  = de;
        regs[0]  = bc;
        wait_cfg = wt;
        cen_mode = cm;
        int_req  = 1'b0;
        int_at   = ia;
        rdn      = 0;
        dir      = d;
        rpt      = r;
        start    = 1'b1;
        for (cyc = 0; cyc < 100 && !busy; cyc++) step();
        start = 1'b0;
        lim = 400 + n * 40 * (wt + 1);
        for (cyc = 0; cyc < lim && (exq.size() != 0 || busy); cyc++) step();
        if (exq.size() != 0 || busy) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got pending=%0d busy=%0b expected pending=0 busy=0", nm, exq.size(), busy);
            do_reset();
        end else begin
            chk({nm, "_busy"}, 34'(busy), 34'(0));
            chk({nm, "_hl"}, 34'(regs[2]), 34'(h));
            chk({nm, "_de"}, 34'(regs[1]), 34'(e));
            chk({nm, "_bc"}, 34'(regs[0]), 34'(b));
            chk({nm, "_pv"}, 34'(pv), 34'(b != 16'h0000));
        end
        int_req  = 1'b0;
        int_at   = 0;
        cen_mode = 0;
        step();
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got no end of run expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [15:0] bc;
        logic        r;
        int          ia;
        for (int i = 0; i < 65536; i++) begin
            mem[i]  = 8'($urandom);
            mmem[i] = mem[i];
        end
        for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);
        repeat (2) step();
        chk("rst_outputs", 34'({busy, done, rpt_break, pv, mem_req, mem_we, mem_addr, mem_wdata,
                               rf_weh, rf_wel}), 34'(0));
        chk("rst_rfdata", 34'({rf_dih, rf_dil}), 34'(0));
        chk("rst_addrs", 34'({rf_addr_a, rf_addr_b, rf_addr_c}), 34'({3'd0, 3'd2, 3'd1}));
        RESET_n = 1'b1;
        step();

        mem[16'h1000] = 8'h5A;
        mmem[16'h1000] = 8'h5A;
        issue("ldi", 16'h1000, 16'h2000, 16'h0003, 1'b0, 1'b0, 0, 0, 0);
        chk("ldi_dest", 34'(mem[16'h2000]), 34'(8'h5A));
        chk("ldi_bc_const", 34'(regs[0]), 34'(16'h0002));

        issue("lddr", 16'h0001, 16'h8001, 16'h0003, 1'b1, 1'b1, 0, 0, 0);
        chk("lddr_hl_const", 34'(regs[2]), 34'(16'hFFFE));
        issue("ldir1", 16'h4000, 16'h5000, 16'h0001, 1'b0, 1'b1, 0, 0, 0);
        issue("ldir_int", 16'h6000, 16'h7000, 16'd10, 1'b0, 1'b1, 2, 0, 0);
        chk("ldir_int_bc_const", 34'(regs[0]), 34'(16'd8));
        issue("ldir_fast", 16'h3000, 16'h9000, 16'd4, 1'b0, 1'b1, 0, 0, 0);
        issue("ldir_slow", 16'h3000, 16'h9000, 16'd4, 1'b0, 1'b1, 0, 3, 1);
        issue("ldi_bc0", 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 0, 1, 2);

        // Reset while the write is stalled waiting for ack.
        sb_en    = 1'b0;
        regs[2]  = 16'hA000;
        regs[1]  = 16'hB000;
        regs[0]  = 16'd5;
        wait_cfg = 2;
        rpt      = 1'b1;
        dir      = 1'b0;
        start    = 1'b1;
        for (int c = 0; c < 100 && !busy; c++) step();
        start = 1'b0;
        for (int c = 0; c < 100 && !(mem_req && mem_we); c++) @(negedge clk);
        chk("rst_reach_wr", 34'({mem_req, mem_we}), 34'(2'b11));
        #2;
        RESET_n = 1'b0;
        #1;
        chk("rst_async_req", 34'(mem_req), 34'(0));
        repeat (2) step();
        exq.delete();
        resync_mem();
        RESET_n = 1'b1;
        step();
        chk("rst_after", 34'({busy, done}), 34'(0));
        sb_en = 1'b1;
        issue("post_rst", 16'h1234, 16'h4321, 16'h0002, 1'b1, 1'b0, 0, 0, 0);

        for (int t = 0; t < 40; t++) begin
            r  = 1'($urandom_range(0, 1));
            bc = r ? 16'($urandom_range(1, 6)) : 16'($urandom);
            if (!r && $urandom_range(0, 4) == 0) bc = 16'h0000;
            ia = (r && $urandom_range(0, 1) == 1) ? $urandom_range(1, int'(bc)) : 0;
            issue("rand", 16'($urandom), 16'($urandom), bc, 1'($urandom_range(0, 1)), r,
                  ia, $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
